mul_sequencer: RTL
==================

# mul_sequencer

Front-end and sign-correction controller for the iterative 32×32 shift-add multiplier. It accepts RV32M multiply requests over a valid/ready handshake and converts signed operands to magnitudes. It drives the multiplier's operand and enable inputs for a fixed number of cycles, then captures the unsigned 64-bit product. It applies two's-complement correction, selects the low or high word, and presents the result downstream with a valid/ready handshake.

## Interface
- `MUL_CYCLES`, default 34: number of consecutive cycles `mul_enable` is held high before the product on `mul_lower`/`mul_higher` is final.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready` at a rising edge.
- `in_op` in 2: 00 MUL (low word, signedness irrelevant); 01 MULH (s×s, high); 10 MULHSU (s×u, high); 11 MULHU (u×u, high).
- `in_a`, `in_b` in 32 each: operands.
- `flush` in 1: synchronous abort of any in-flight request.
- `mul_a`, `mul_b` out 32 each: magnitude operands to the multiplier.
- `mul_signed_a`, `mul_signed_b` out 1 each: tied 0; the multiplier always runs unsigned.
- `mul_enable` out 1: multiplier enable.
- `mul_lower`, `mul_higher` in 32 each: multiplier product.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid & out_ready` at a rising edge.
- `out_result` out 32: selected result word.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - `in_ready`=1, `mul_enable`=0.
  - On accept, register the following:
    - `sa` = `in_a[31]` if op ∈ {01,10}, else 0.
    - `sb` = `in_b[31]` if op = 01, else 0.
    - `mul_a` = `sa ? -in_a : in_a` (32-bit wrap; 0x80000000 stays 0x80000000, a correct unsigned magnitude). `mul_b` is formed the same way from `sb`.
    - `neg` = `sa ^ sb`.
    - `op`.
  - Next state is RUN.
- RUN:
  - `mul_enable`=1.
  - A 6-bit counter starts at 0 and increments each cycle.
  - When the counter equals `MUL_CYCLES-1`, go to FIXUP.
  - `mul_a`/`mul_b` are held stable for the whole of RUN.
- FIXUP:
  - `mul_enable`=0.
  - Form `p` = {`mul_higher`,`mul_lower`}, and `p` = `neg ? (~p + 1) : p` as a 64-bit two's complement.
  - `out_result` ← `p[31:0]` for op 00, else `p[63:32]`.
  - Next state is DONE.
- DONE:
  - `out_valid`=1.
  - `out_result` is held stable until consumed.
  - On `out_ready`, go to IDLE.
- `mul_enable` is low for at least one cycle between requests, because IDLE always lasts at least one cycle. This low cycle restarts the multiplier's bit index.
- `flush`:
  - In any state, the next state is IDLE. `mul_enable`, `out_valid` and the counter are cleared. Any pending result is discarded.
  - `flush` with `in_valid` in IDLE: flush wins and nothing is accepted.
- Reset (async, any state):
  - State IDLE; counter 0; `mul_enable`=0; `out_valid`=0; `busy`=0.
  - `in_ready`=1; `out_result`, `mul_a`, `mul_b` = 0.
  - `mul_signed_a`/`mul_signed_b` = 0.

## Timing
- Accept edge is E0. `mul_enable` is high after E0 through edge E0+`MUL_CYCLES`, i.e. exactly `MUL_CYCLES` enabled edges.
- FIXUP occupies the cycle after the last RUN edge. `out_valid` rises after edge E0+`MUL_CYCLES`+1, so accept-to-valid latency is `MUL_CYCLES`+1 cycles (35 at default).
- The product is sampled in FIXUP only; no output depends combinationally on `mul_lower`/`mul_higher`.
- `in_ready` is a registered state decode and is never combinational on `in_valid`.
- Throughput is one request per `MUL_CYCLES`+3 cycles with `out_ready` held high: RUN, FIXUP, DONE, IDLE.
- `out_ready` while not in DONE is ignored. `in_valid` while not in IDLE is ignored and not queued.

## Test plan
- MUL, `in_a`=7, `in_b`=6 with a behavioural multiplier model → `out_result`=0x0000002A. `out_valid` rises exactly 35 cycles after accept, and `mul_enable` is high for exactly 34 cycles.
- MULH, 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULH, 0x80000000×0x80000000 → 0x40000000 (`mul_a`=`mul_b`=0x80000000, `neg`=0).
- MULHSU, 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF (full product 0xFFFFFFFF_00000001). MULHU with the same operands → 0xFFFFFFFE.
- Backpressure: `out_ready` low for 10 cycles after `out_valid` → `out_result` stable and `in_ready`=0 throughout; accept-to-accept gap for back-to-back requests is 37 cycles.
- `flush` asserted 5 cycles into RUN → `mul_enable`=0 and IDLE next cycle, with no `out_valid`. A following MUL 3×5 → 0x0000000F.
- `reset_n` pulsed low mid-RUN → all outputs reach their reset values immediately without a clock edge. A following MULHU 0x00010000×0x00010000 → 0x00000001.

Source files
------------

// File: rtl/mul_sequencer.sv
// mul_sequencer: RV32M multiply front-end driving an unsigned iterative multiplier with sign fix-up
module mul_sequencer #(
  parameter int MUL_CYCLES = 34
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        flush,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed_a,
  output logic        mul_signed_b,
  output logic        mul_enable,
  input  logic [31:0] mul_lower,
  input  logic [31:0] mul_higher,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
  localparam logic [5:0] LAST = 6'(MUL_CYCLES - 1);
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, out_result_q, out_result_d;
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic        in_ready_q, in_ready_d, busy_q, busy_d;
  logic        mul_enable_q, mul_enable_d, out_valid_q, out_valid_d;
  logic        sa, sb;
  logic [63:0] p, p_fix;
  // Next-state and datapath: operands become magnitudes on accept, product is sign-corrected in FIXUP
  always_comb begin
    sa = in_a[31] & (in_op[0] ^ in_op[1]);
    sb = in_b[31] & (in_op == 2'b01);
    p = {mul_higher, mul_lower};
    p_fix = neg_q ? ~p + 64'd1 : p;
    state_d = state_q;
    cnt_d = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    op_d = op_q;
    neg_d = neg_q;
    out_result_d = out_result_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        cnt_d = 6'd0;
        mul_a_d = sa ? -in_a : in_a;
        mul_b_d = sb ? -in_b : in_b;
        neg_d = sa ^ sb;
        op_d = in_op;
      end
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == LAST) ? FIXUP : RUN;
      end
      FIXUP: begin
        out_result_d = (op_q == 2'b00) ? p_fix[31:0] : p_fix[63:32];
        state_d = DONE;
      end
      default: state_d = out_ready ? IDLE : DONE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d = 6'd0;
    end
    in_ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    mul_enable_d = state_d == RUN;
    out_valid_d = state_d == DONE;
  end
  // State, datapath and registered handshake/enable outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= 6'd0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
      op_q <= 2'b00;
      neg_q <= 1'b0;
      out_result_q <= 32'd0;
      in_ready_q <= 1'b1;
      busy_q <= 1'b0;
      mul_enable_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      op_q <= op_d;
      neg_q <= neg_d;
      out_result_q <= out_result_d;
      in_ready_q <= in_ready_d;
      busy_q <= busy_d;
      mul_enable_q <= mul_enable_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready = in_ready_q;
  assign busy = busy_q;
  assign mul_enable = mul_enable_q;
  assign out_valid = out_valid_q;
  assign out_result = out_result_q;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign mul_signed_a = 1'b0;
  assign mul_signed_b = 1'b0;
endmodule
